// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter: round-robin two-port sequencer for a strobe-clocked FIFO; `define FIFO_ARB_OCC_COUNT_EN adds occ output and occupancy-based gating
module fifo_access_arbiter #(
  parameter int WIDTH = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC = 2,
  parameter int DEPTH = 8
) (
  input  logic               clk100MHz,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [1:0]         req_wnr,
  input  logic [2*WIDTH-1:0] req_wdata,
  output logic [1:0]         ack,
  output logic               err,
  output logic [WIDTH-1:0]   rdata,
  output logic               fifo_wnr,
  output logic               fifo_en,
  output logic [WIDTH-1:0]   fifo_in,
  output logic               fifo_step,
  input  logic [WIDTH-1:0]   fifo_out,
  input  logic               fifo_full,
  input  logic               fifo_empty,
`ifdef FIFO_ARB_OCC_COUNT_EN
  output logic [$clog2(DEPTH):0] occ,
`endif
  output logic               busy
);
  localparam int CW = $clog2(SETUP_CYC + PULSE_CYC + HOLD_CYC + DEPTH) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, REJECT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d, grant_q, grant_d;
  logic [1:0] ack_q, ack_d;
  logic err_q, err_d, wnr_q, wnr_d, en_q, en_d, step_q, step_d, busy_q, busy_d;
  logic [WIDTH-1:0] rdata_q, rdata_d, in_q, in_d;
  logic gnt, wr, full, empty;
  logic [WIDTH-1:0] wd;
  assign gnt = req[!last_q] ? !last_q : last_q;
  assign wr = req_wnr[gnt];
  assign wd = gnt ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
`ifdef FIFO_ARB_OCC_COUNT_EN
  localparam int OW = $clog2(DEPTH) + 1;
  logic [OW-1:0] occ_q, occ_d;
  assign full = occ_q == OW'(DEPTH);
  assign empty = occ_q == '0;
  assign occ = occ_q;
  always_comb occ_d = state_q == DONE ? (wnr_q ? occ_q + 1'b1 : occ_q - 1'b1) : occ_q;
  always_ff @(posedge clk100MHz) occ_q <= reset ? '0 : occ_d;
`else
  assign full = fifo_full;
  assign empty = fifo_empty;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    grant_d = grant_q;
    ack_d = '0;
    err_d = 1'b0;
    rdata_d = rdata_q;
    wnr_d = wnr_q;
    en_d = en_q;
    in_d = in_q;
    step_d = step_q;
    case (state_q)
      IDLE: if (|req) begin
        last_d = gnt;
        grant_d = gnt;
        cnt_d = '0;
        if (wr ? full : empty) begin
          state_d = REJECT;
          ack_d = {gnt, !gnt};
          err_d = 1'b1;
        end else begin
          state_d = SETUP;
          en_d = 1'b1;
          wnr_d = wr;
          in_d = wd;
        end
      end
      SETUP: begin
        cnt_d = cnt_q == CW'(SETUP_CYC - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(SETUP_CYC - 1) ? STROBE : SETUP;
        step_d = cnt_q == CW'(SETUP_CYC - 1);
      end
      STROBE: begin
        cnt_d = cnt_q == CW'(PULSE_CYC - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(PULSE_CYC - 1) ? HOLD : STROBE;
        step_d = cnt_q != CW'(PULSE_CYC - 1);
      end
      HOLD: if (cnt_q == CW'(HOLD_CYC - 1)) begin
        state_d = DONE;
        cnt_d = '0;
        ack_d = {grant_q, !grant_q};
        en_d = 1'b0;
        rdata_d = wnr_q ? rdata_q : fifo_out;
      end else cnt_d = cnt_q + 1'b1;
      DONE: state_d = IDLE;
      REJECT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk100MHz)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      grant_q <= 1'b0;
      ack_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      wnr_q <= 1'b0;
      en_q <= 1'b0;
      in_q <= '0;
      step_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      wnr_q <= wnr_d;
      en_q <= en_d;
      in_q <= in_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  assign ack = ack_q;
  assign err = err_q;
  assign rdata = rdata_q;
  assign fifo_wnr = wnr_q;
  assign fifo_en = en_q;
  assign fifo_in = in_q;
  assign fifo_step = step_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb_fifo_access_arbiter: directed checks of fifo_access_arbiter against a strobe-clocked FIFO model
module tb_fifo_access_arbiter;
  logic clk100MHz = 1'b0;
  logic reset;
  logic [1:0] req, req_wnr, ack;
  logic [7:0] req_wdata;
  logic err, fifo_wnr, fifo_en, fifo_step, fifo_full, fifo_empty, busy;
  logic [3:0] rdata, fifo_in, fifo_out;
`ifdef FIFO_ARB_OCC_COUNT_EN
  logic [3:0] occ;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [12:0] step_tr, en_tr, wnr_tr;
  logic [3:0] in_k1, rd_v;
  logic [1:0] ack_v, ack_after;
  logic err_v, busy_after;
  int k_ack;
  logic [7:0] seq;
  int n_ack, c_first, c_last;
  logic [3:0] mem [8];
  int fcnt, rp, wp;
  logic [3:0] fout;
  logic step_prev;

  fifo_access_arbiter dut (
    .clk100MHz(clk100MHz), .reset(reset), .req(req), .req_wnr(req_wnr), .req_wdata(req_wdata),
    .ack(ack), .err(err), .rdata(rdata), .fifo_wnr(fifo_wnr), .fifo_en(fifo_en), .fifo_in(fifo_in),
    .fifo_step(fifo_step), .fifo_out(fifo_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
`ifdef FIFO_ARB_OCC_COUNT_EN
    .occ(occ),
`endif
    .busy(busy)
  );

  always #5 clk100MHz = ~clk100MHz;

  always @(posedge clk100MHz) begin
    step_prev <= fifo_step;
    if (reset) begin
      fcnt <= 0;
      rp <= 0;
      wp <= 0;
      fout <= '0;
    end else if (fifo_step && !step_prev && fifo_en) begin
      if (fifo_wnr && fcnt < 8) begin
        mem[wp] <= fifo_in;
        wp <= (wp + 1) % 8;
        fcnt <= fcnt + 1;
      end else if (!fifo_wnr && fcnt > 0) begin
        fout <= mem[rp];
        rp <= (rp + 1) % 8;
        fcnt <= fcnt - 1;
      end
    end
  end
  assign fifo_full = fcnt == 8;
  assign fifo_empty = fcnt == 0;
  assign fifo_out = fout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [1:0] r, input logic [1:0] w, input logic [7:0] d);
    req = r;
    req_wnr = w;
    req_wdata = d;
    step_tr = '0;
    en_tr = '0;
    wnr_tr = '0;
    in_k1 = '0;
    k_ack = 0;
    ack_v = '0;
    err_v = 1'b0;
    rd_v = '0;
    for (int k = 1; k <= 12 && k_ack == 0; k++) begin
      @(negedge clk100MHz);
      step_tr[k] = fifo_step;
      en_tr[k] = fifo_en;
      wnr_tr[k] = fifo_wnr;
      if (k == 1) in_k1 = fifo_in;
      if (ack != 2'b00) begin
        k_ack = k;
        ack_v = ack;
        err_v = err;
        rd_v = rdata;
      end
    end
    req = 2'b00;
    @(negedge clk100MHz);
    busy_after = busy;
    ack_after = ack;
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_wnr = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk100MHz);
    chk("reset_outputs", {ack, err, rdata, fifo_wnr, fifo_en, fifo_in, fifo_step, busy}, 0);
    reset = 1'b0;
    @(negedge clk100MHz);

    op(2'b01, 2'b01, 8'h0A);
    chk("wr_ack_cycle", k_ack, 7);
    chk("wr_ack_port", {ack_v, err_v}, {2'b01, 1'b0});
    chk("wr_step_trace", step_tr, 13'h018);
    chk("wr_en_trace", en_tr, 13'h07E);
    chk("wr_wnr_trace", wnr_tr[6:1], 6'h3F);
    chk("wr_fifo_in", in_k1, 4'hA);
    chk("wr_after", {busy_after, ack_after}, 0);

    op(2'b10, 2'b00, 8'h00);
    chk("rd_ack_cycle", k_ack, 7);
    chk("rd_ack_port", {ack_v, err_v}, {2'b10, 1'b0});
    chk("rd_rdata", rd_v, 4'hA);
    chk("rd_wnr_trace", wnr_tr[6:1], 6'h00);
    chk("rd_step_trace", step_tr, 13'h018);

    req = 2'b11;
    req_wnr = 2'b11;
    req_wdata = 8'h21;
    seq = '0;
    n_ack = 0;
    c_first = 0;
    c_last = 0;
    for (int c = 1; c <= 40 && n_ack < 4; c++) begin
      @(negedge clk100MHz);
      if (ack != 2'b00) begin
        seq = {seq[5:0], ack};
        if (n_ack == 0) c_first = c;
        c_last = c;
        n_ack++;
      end
    end
    req = 2'b00;
    @(negedge clk100MHz);
    chk("alt_grant_seq", seq, 8'h66);
    chk("alt_ack_spacing", c_last - c_first, 24);

    op(2'b01, 2'b00, 8'h00);
    chk("readback0", rd_v, 4'h1);
    op(2'b01, 2'b00, 8'h00);
    chk("readback1", rd_v, 4'h2);
    op(2'b01, 2'b00, 8'h00);
    chk("readback2", rd_v, 4'h1);
    op(2'b01, 2'b00, 8'h00);
    chk("readback3", rd_v, 4'h2);

    op(2'b10, 2'b00, 8'h00);
    chk("empty_rd_ack_cycle", k_ack, 1);
    chk("empty_rd_ack", {ack_v, err_v}, {2'b10, 1'b1});
    chk("empty_rd_no_strobe", {step_tr, en_tr}, 0);
    chk("empty_rd_rdata_kept", rd_v, 4'h2);
    chk("empty_rd_after", {busy_after, ack_after}, 0);

    for (int i = 0; i < 8; i++) begin
      op(2'b01, 2'b01, 8'(i));
      chk("fill_ack", {k_ack[3:0], ack_v, err_v}, {4'd7, 2'b01, 1'b0});
    end
    chk("fill_model_count", fcnt, 8);
`ifdef FIFO_ARB_OCC_COUNT_EN
    chk("fill_occ", occ, 8);
`endif
    op(2'b01, 2'b01, 8'h0F);
    chk("full_wr_ack_cycle", k_ack, 1);
    chk("full_wr_ack", {ack_v, err_v}, {2'b01, 1'b1});
    chk("full_wr_no_strobe", step_tr, 0);
    chk("full_wr_model_count", fcnt, 8);
`ifdef FIFO_ARB_OCC_COUNT_EN
    chk("full_occ_held", occ, 8);
`endif

    req = 2'b01;
    req_wnr = 2'b00;
    repeat (3) @(negedge clk100MHz);
    chk("mid_strobe_high", fifo_step, 1);
    reset = 1'b1;
    @(negedge clk100MHz);
    chk("mid_reset_outs", {fifo_step, fifo_en, busy, ack}, 0);
    reset = 1'b0;
    op(2'b11, 2'b11, 8'h21);
    chk("post_reset_grant", {ack_v, err_v}, {2'b01, 1'b0});
    chk("post_reset_data", in_k1, 4'h1);
`ifdef FIFO_ARB_OCC_COUNT_EN
    chk("post_reset_occ", occ, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
